rtc_bcd_timekeeper: RTL
=======================

Name: rtc_bcd_timekeeper

Overview:
- Single-clock-domain BCD time-of-day counter for hours, minutes and seconds.
- Replaces ripple-clocked counter chains with one divider that generates a one-cycle second-tick enable; all registers run on clk.
- Adds parametrised tick divisor, run/hold, legal-checked time load, 12/24-hour display mode, and tick/midnight strobes.
- Feeds the 7-segment decoder stage directly: six BCD nibbles.

Parameters:
- CLK_DIV, 50000000, clk cycles per one-second tick; legal range 2..2^32-1; divider width = clog2(CLK_DIV).
- SEC_START, 8'h00, BCD seconds value loaded at reset.
- MIN_START, 8'h00, BCD minutes value loaded at reset.
- HOUR_START, 8'h00, BCD hours (24h form) value loaded at reset.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- run  input  1  1 = advance time on each tick; 0 = hold time and divider
- mode12  input  1  1 = 12-hour display, 0 = 24-hour display
- set_valid  input  1  one-cycle load strobe
- set_hour  input  8  BCD hours, always 24h form (00..23)
- set_min  input  8  BCD minutes (00..59)
- set_sec  input  8  BCD seconds (00..59)
- set_err  output  1  one-cycle pulse: rejected load
- sec  output  8  BCD seconds
- min  output  8  BCD minutes
- hour  output  8  BCD hours, display form per mode12
- pm  output  1  1 when internal hour >= 12, in either mode
- sec_tick  output  1  one-cycle pulse when seconds advanced
- day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (reset=0, asynchronous):
  - Divider = 0; time registers = HOUR_START:MIN_START:SEC_START.
  - set_err, sec_tick and day_wrap = 0.
- Divider:
  - Counts 0..CLK_DIV-1 only while run=1; on reaching CLK_DIV-1 it wraps to 0 and raises internal tick for that cycle.
  - When run=0 the divider freezes (not cleared), so the partial second is preserved.
- Time advance on tick, all digits updated in the same cycle:
  - sec_lo 9 -> 0 carries to sec_hi; sec_hi 5 with sec_lo 9 -> 00 carries to minutes.
  - Minutes behave the same as seconds.
  - Hours count 00..23 in BCD: 09 -> 10, 19 -> 20, 23 -> 00.
- Outputs are registered; sec_tick and day_wrap assert in the cycle after the tick, together with the new time value.
- Load:
  - set_valid=1 with all fields legal (each nibble <= 9, sec/min <= 59, hour <= 23): time loads next cycle and the divider clears to 0, so the next tick arrives a full CLK_DIV later.
  - An illegal field rejects the whole load: time is unchanged, divider is unchanged, and set_err pulses for one cycle.
  - Load has priority over a tick in the same cycle; that tick is discarded and no sec_tick or day_wrap is issued.
  - Load works regardless of run.
- Display conversion (combinational from internal 24h hour and mode12):
  - mode12=0: hour = internal hour.
  - mode12=1: 00 -> 12, 01..12 unchanged, 13..23 -> 01..11.
  - Toggling mode12 changes hour combinationally and never alters internal state.
- Illegal internal states cannot occur. Any nibble > 9 reached via a start parameter is treated as a digit wrap: it resets to 0 and carries on the next tick.
- Reset asserted mid-second or mid-load aborts the operation; the state after release is the pure reset state.

Optional Feature:
- Macro: RTC_ALARM_EN.
- When defined, the block adds these ports:
  - alarm_set input 1
  - alarm_hour input 8
  - alarm_min input 8
  - alarm_ack input 1
  - alarm_irq output 1
- alarm_set latches alarm_hour:alarm_min, with the same legality check; an illegal value pulses set_err.
- alarm_irq sets in the cycle time registers become alarm_hour:alarm_min:00 via a tick. Loading that exact time via set_valid does not trigger it.
- alarm_irq stays high until alarm_ack=1; if ack and a new match coincide, set wins.
- Alarm registers reset to 00:00 and alarm_irq resets to 0.
- When the macro is undefined, none of these ports or registers exist.

Test Plan:
- CLK_DIV=4, reset release, run=1 -> sec_tick every 4 cycles; after 40 ticks sec=8'h40, min=8'h00.
- Load 23:59:58, run=1 -> after 2 ticks time 00:00:00, day_wrap single pulse coincident with sec_tick, pm 1 -> 0.
- Load with set_min=8'h60, then set_sec=8'h1A -> set_err pulses each time, time unchanged; load of 12:34:56 -> succeeds with no set_err.
- set_valid asserted in the divider-wrap cycle -> loaded value held, no sec_tick that cycle, next tick exactly 4 cycles later; run=0 for 10 cycles mid-second -> no ticks, remaining count resumes.
- mode12=1 at internal 00, 12 and 13 hours -> hour 12/pm=0, 12/pm=1, 01/pm=1; reset pulsed mid-count -> time equals the HOUR_START/MIN_START/SEC_START parameters.
- RTC_ALARM_EN: alarm 00:01, start 00:00:58 -> alarm_irq rises 2 ticks later, holds until alarm_ack, and does not re-fire on the following tick.

Source files
------------

// File: rtl/rtc_bcd_timekeeper.sv
// BCD time-of-day counter (hh:mm:ss) driven by one clk-domain second divider.
// Optional alarm block is enabled with `define RTC_ALARM_EN.
//
// Ports:
//   clk, reset (async, active low)
//   run        : advance time and divider when 1, freeze both when 0
//   mode12     : 1 = 12-hour display on hour, 0 = 24-hour display
//   set_valid  : load strobe for set_hour/set_min/set_sec (BCD, 24h)
//   set_err    : one-cycle pulse when a load (or alarm set) is rejected
//   sec/min    : BCD seconds/minutes
//   hour       : BCD hours in display form
//   pm         : internal hour >= 12
//   sec_tick   : one-cycle pulse with each second advance
//   day_wrap   : one-cycle pulse on 23:59:59 -> 00:00:00
//   alarm_set, alarm_hour, alarm_min, alarm_ack, alarm_irq (RTC_ALARM_EN)

module rtc_bcd_timekeeper #(
    parameter int unsigned CLK_DIV    = 50000000,
    parameter logic [7:0]  SEC_START  = 8'h00,
    parameter logic [7:0]  MIN_START  = 8'h00,
    parameter logic [7:0]  HOUR_START = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode12,
    input  logic       set_valid,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
`ifdef RTC_ALARM_EN
    input  logic       alarm_set,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_ack,
    output logic       alarm_irq,
`endif
    output logic       set_err,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    function automatic logic bcd_ok(input logic [7:0] v,
                                    input logic [3:0] hi_max);
        return (v[7:4] <= hi_max) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        return bcd_ok(v, 4'd2) && ((v[7:4] != 4'd2) || (v[3:0] <= 4'd3));
    endfunction

    logic [DIV_W-1:0] div_q;
    logic [7:0]       sec_q, min_q, hour_q;
    logic             tick;
    logic             load_ok, load_bad;

    assign tick     = run && (div_q == DIV_MAX);
    assign load_ok  = set_valid && bcd_ok(set_sec, 4'd5)
                      && bcd_ok(set_min, 4'd5) && hour_ok(set_hour);
    assign load_bad = set_valid && !load_ok;

    // Next time value, all digits in one step. A nibble at or above its
    // limit wraps to zero and carries, which also clears out-of-range
    // digits that came from start parameters.
    logic [7:0] nxt_sec, nxt_min, nxt_hour;
    logic       s_lo_w, s_hi_w, m_lo_w, m_hi_w, h_wrap, day_w;

    always_comb begin
        s_lo_w = sec_q[3:0] >= 4'd9;
        s_hi_w = s_lo_w && (sec_q[7:4] >= 4'd5);
        nxt_sec[3:0] = s_lo_w ? 4'd0 : sec_q[3:0] + 4'd1;
        nxt_sec[7:4] = !s_lo_w ? sec_q[7:4] :
                       (s_hi_w ? 4'd0 : sec_q[7:4] + 4'd1);

        m_lo_w = s_hi_w && (min_q[3:0] >= 4'd9);
        m_hi_w = m_lo_w && (min_q[7:4] >= 4'd5);
        nxt_min[3:0] = !s_hi_w ? min_q[3:0] :
                       (m_lo_w ? 4'd0 : min_q[3:0] + 4'd1);
        nxt_min[7:4] = !m_lo_w ? min_q[7:4] :
                       (m_hi_w ? 4'd0 : min_q[7:4] + 4'd1);

        h_wrap = (hour_q[7:4] > 4'd2)
                 || ((hour_q[7:4] == 4'd2) && (hour_q[3:0] >= 4'd3));
        nxt_hour = hour_q;
        if (m_hi_w) begin
            if (h_wrap)
                nxt_hour = 8'h00;
            else if (hour_q[3:0] >= 4'd9)
                nxt_hour = {hour_q[7:4] + 4'd1, 4'd0};
            else
                nxt_hour = {hour_q[7:4], hour_q[3:0] + 4'd1};
        end
        day_w = m_hi_w && h_wrap;
    end

`ifdef RTC_ALARM_EN
    logic [7:0] al_hour_q, al_min_q;
    logic       al_ok, al_bad, al_match;

    assign al_ok    = alarm_set && bcd_ok(alarm_min, 4'd5)
                      && hour_ok(alarm_hour);
    assign al_bad   = alarm_set && !al_ok;
    // Only a tick-driven advance can fire; a direct load never does.
    assign al_match = tick && !load_ok && (nxt_sec == 8'h00)
                      && (nxt_min == al_min_q) && (nxt_hour == al_hour_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_hour_q <= 8'h00;
            al_min_q  <= 8'h00;
            alarm_irq <= 1'b0;
        end else begin
            if (al_ok) begin
                al_hour_q <= alarm_hour;
                al_min_q  <= alarm_min;
            end
            if (al_match)
                alarm_irq <= 1'b1;
            else if (alarm_ack)
                alarm_irq <= 1'b0;
        end
    end
`else
    logic al_bad;
    assign al_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            sec_q    <= SEC_START;
            min_q    <= MIN_START;
            hour_q   <= HOUR_START;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            set_err  <= load_bad || al_bad;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            if (load_ok) begin
                // Load wins over a coincident tick, which is dropped.
                div_q  <= '0;
                sec_q  <= set_sec;
                min_q  <= set_min;
                hour_q <= set_hour;
            end else begin
                if (run)
                    div_q <= tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    sec_q    <= nxt_sec;
                    min_q    <= nxt_min;
                    hour_q   <= nxt_hour;
                    sec_tick <= 1'b1;
                    day_wrap <= day_w;
                end
            end
        end
    end

    // Display conversion from the internal 24h hour.
    logic [7:0] h_bin, d_bin;
    logic [3:0] d_lo;

    always_comb begin
        h_bin = {4'd0, hour_q[7:4]} * 8'd10 + {4'd0, hour_q[3:0]};
        pm    = h_bin >= 8'd12;
        if (h_bin == 8'd0)
            d_bin = 8'd12;
        else if (h_bin > 8'd12)
            d_bin = h_bin - 8'd12;
        else
            d_bin = h_bin;
        d_lo = (d_bin >= 8'd10) ? 4'(d_bin - 8'd10) : d_bin[3:0];
        if (mode12)
            hour = {(d_bin >= 8'd10) ? 4'd1 : 4'd0, d_lo};
        else
            hour = hour_q;
    end

    assign sec = sec_q;
    assign min = min_q;

endmodule
